// File: rtl/rx_error_counter.sv
// PRBS7 receive checker: slices pre-emphasized samples, hunts for lock,
// then counts bit errors against a free-running local LFSR.
module rx_error_counter #(
   parameter int CNT_W       = 32,
   parameter int LOCK_CNT    = 16,
   parameter int LOSS_THRESH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       din,
   input  logic             din_valid,
   input  logic             clear,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             cnt_sat
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int EW = $clog2(LOSS_THRESH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

   typedef enum logic {
      S_HUNT,
      S_LOCKED
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [6:0]    sr;
   logic [6:0]    sr_nx;
   logic [6:0]    lfsr;
   logic [6:0]    lfsr_nx;
   logic [2:0]    fill;
   logic [2:0]    fill_nx;
   logic [MW-1:0] match;
   logic [MW-1:0] match_nx;
   logic [5:0]    win;
   logic [5:0]    win_nx;
   logic [EW-1:0] win_err;
   logic [EW-1:0] win_err_nx;
   logic          rx_bit;
   logic          hist_pred;
   logic          lfsr_pred;
   logic          mis;
   logic          cnt_bit;
   logic          sat_hit;

   assign rx_bit    = ~din[7];
   assign hist_pred = sr[6] ^ sr[5];
   assign lfsr_pred = lfsr[6] ^ lfsr[5];
   assign locked    = (state == S_LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_HUNT;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      sr_nx      = sr;
      lfsr_nx    = lfsr;
      fill_nx    = fill;
      match_nx   = match;
      win_nx     = win;
      win_err_nx = win_err;
      mis        = 1'b0;
      cnt_bit    = 1'b0;
      if (din_valid) begin
         sr_nx = {sr[5:0], rx_bit};
         unique case (state)
            S_HUNT: begin
               if (fill != 3'd7) begin
                  fill_nx = fill + 3'd1;
               end else if (rx_bit == hist_pred) begin
                  match_nx = match + 1'b1;
                  if (match_nx == MW'(LOCK_CNT)) begin
                     state_nx = S_LOCKED;
                     lfsr_nx  = {sr[5:0], rx_bit};
                     match_nx = '0;
                  end
               end else begin
                  match_nx = '0;
               end
            end
            S_LOCKED: begin
               // local LFSR free-runs so one corrupt bit is counted once
               lfsr_nx = {lfsr[5:0], lfsr_pred};
               mis     = (rx_bit != lfsr_pred);
               cnt_bit = 1'b1;
               win_nx  = win + 6'd1;
               if (mis) begin
                  win_err_nx = win_err + 1'b1;
               end
               if (mis && win_err_nx == EW'(LOSS_THRESH)) begin
                  state_nx   = S_HUNT;
                  fill_nx    = '0;
                  match_nx   = '0;
                  win_nx     = '0;
                  win_err_nx = '0;
               end else if (win == 6'd63) begin
                  win_err_nx = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sat_hit = (cnt_bit && bit_cnt == CNT_PRE)
                  || (mis && err_cnt == CNT_PRE);

   always_ff @(posedge clk) begin
      if (reset) begin
         sr      <= '0;
         lfsr    <= '0;
         fill    <= '0;
         match   <= '0;
         win     <= '0;
         win_err <= '0;
         bit_err <= 1'b0;
         err_cnt <= '0;
         bit_cnt <= '0;
         cnt_sat <= 1'b0;
      end else begin
         sr      <= sr_nx;
         lfsr    <= lfsr_nx;
         fill    <= fill_nx;
         match   <= match_nx;
         win     <= win_nx;
         win_err <= win_err_nx;
         bit_err <= mis;
         if (clear) begin
            err_cnt <= '0;
            bit_cnt <= '0;
            cnt_sat <= 1'b0;
         end else begin
            if (cnt_bit && bit_cnt != CNT_MAX) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
            if (mis && err_cnt != CNT_MAX) begin
               err_cnt <= err_cnt + 1'b1;
            end
            if (sat_hit) begin
               cnt_sat <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_error_counter.sv
// Directed bench for rx_error_counter: a default instance and a
// CNT_W=4 instance share one stimulus stream.
module tb_rx_error_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  din;
   logic        din_valid;
   logic        clear;

   logic        a_locked;
   logic        a_bit_err;
   logic [31:0] a_err_cnt;
   logic [31:0] a_bit_cnt;
   logic        a_cnt_sat;

   logic        b_locked;
   logic        b_bit_err;
   logic [3:0]  b_err_cnt;
   logic [3:0]  b_bit_cnt;
   logic        b_cnt_sat;

   logic [6:0]  g;
   int          tests = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   rx_error_counter dut_a (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .clear     (clear),
      .locked    (a_locked),
      .bit_err   (a_bit_err),
      .err_cnt   (a_err_cnt),
      .bit_cnt   (a_bit_cnt),
      .cnt_sat   (a_cnt_sat)
   );

   rx_error_counter #(.CNT_W(4)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .clear     (clear),
      .locked    (b_locked),
      .bit_err   (b_bit_err),
      .err_cnt   (b_err_cnt),
      .bit_cnt   (b_bit_cnt),
      .cnt_sat   (b_cnt_sat)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bad=1 negates the sample on the line; the generator still advances
   task automatic send(input logic bad);
      logic nb;
      nb = g[6] ^ g[5];
      g  = {g[5:0], nb};
      din       = (nb ^ bad) ? 8'h40 : 8'hC0;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      din       = 8'($urandom);
      din_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      clear     = 1'b0;
      din       = 8'h00;
      din_valid = 1'b0;
      g         = 7'h7F;
      repeat (2) begin
         din       = 8'($urandom);
         din_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      chk("rst_locked", 64'(a_locked), 64'd0);
      chk("rst_bit_err", 64'(a_bit_err), 64'd0);
      chk("rst_err_cnt", 64'(a_err_cnt), 64'd0);
      chk("rst_bit_cnt", 64'(a_bit_cnt), 64'd0);
      chk("rst_cnt_sat", 64'(a_cnt_sat), 64'd0);
      chk("rst_b_bit_cnt", 64'(b_bit_cnt), 64'd0);
      reset = 1'b0;

      repeat (22) send(1'b0);
      chk("pre_lock", 64'(a_locked), 64'd0);
      send(1'b0);
      chk("lock_23", 64'(a_locked), 64'd1);
      chk("lock_err", 64'(a_err_cnt), 64'd0);
      chk("lock_bits", 64'(a_bit_cnt), 64'd0);
      repeat (10) send(1'b0);
      chk("bits_10", 64'(a_bit_cnt), 64'd10);
      chk("b_bits_10", 64'(b_bit_cnt), 64'd10);
      chk("b_sat_10", 64'(b_cnt_sat), 64'd0);
      repeat (10) send(1'b0);
      chk("bits_20", 64'(a_bit_cnt), 64'd20);
      chk("sat_20", 64'(a_cnt_sat), 64'd0);
      chk("b_bits_sat", 64'(b_bit_cnt), 64'd15);
      chk("b_sat_set", 64'(b_cnt_sat), 64'd1);

      clear = 1'b1;
      send(1'b0);
      clear = 1'b0;
      chk("clr_bits", 64'(a_bit_cnt), 64'd0);
      chk("clr_b_bits", 64'(b_bit_cnt), 64'd0);
      chk("clr_b_sat", 64'(b_cnt_sat), 64'd0);
      chk("clr_locked", 64'(a_locked), 64'd1);

      send(1'b1);
      chk("err1_pulse", 64'(a_bit_err), 64'd1);
      chk("err1_cnt", 64'(a_err_cnt), 64'd1);
      chk("err1_locked", 64'(a_locked), 64'd1);
      send(1'b0);
      chk("err1_pulse_end", 64'(a_bit_err), 64'd0);
      repeat (99) send(1'b0);
      chk("err1_hold", 64'(a_err_cnt), 64'd1);
      chk("err1_bits", 64'(a_bit_cnt), 64'd101);
      chk("err1_lock_hold", 64'(a_locked), 64'd1);
      chk("b_bits_resat", 64'(b_bit_cnt), 64'd15);
      chk("b_sat_reset", 64'(b_cnt_sat), 64'd1);

      // 122 locked bits so far; 6 more close the second window
      repeat (6) send(1'b0);
      clear = 1'b1;
      idle();
      clear = 1'b0;
      chk("clr2_err", 64'(a_err_cnt), 64'd0);
      chk("clr2_bits", 64'(a_bit_cnt), 64'd0);
      chk("clr2_locked", 64'(a_locked), 64'd1);

      repeat (7) send(1'b1);
      chk("loss_7_locked", 64'(a_locked), 64'd1);
      chk("loss_7_err", 64'(a_err_cnt), 64'd7);
      send(1'b1);
      chk("loss_8_locked", 64'(a_locked), 64'd0);
      chk("loss_8_err", 64'(a_err_cnt), 64'd8);
      chk("loss_8_pulse", 64'(a_bit_err), 64'd1);
      chk("loss_8_bits", 64'(a_bit_cnt), 64'd8);
      repeat (22) send(1'b0);
      chk("relock_pre", 64'(a_locked), 64'd0);
      chk("relock_pre_err", 64'(a_err_cnt), 64'd8);
      chk("hunt_no_pulse", 64'(a_bit_err), 64'd0);
      send(1'b0);
      chk("relock", 64'(a_locked), 64'd1);
      chk("relock_err", 64'(a_err_cnt), 64'd8);
      chk("relock_bits", 64'(a_bit_cnt), 64'd8);

      repeat (7) send(1'b1);
      chk("win_7_locked", 64'(a_locked), 64'd1);
      chk("win_7_err", 64'(a_err_cnt), 64'd15);
      repeat (57) send(1'b0);
      send(1'b1);
      chk("wrap_locked", 64'(a_locked), 64'd1);
      chk("wrap_err", 64'(a_err_cnt), 64'd16);
      chk("wrap_bits", 64'(a_bit_cnt), 64'd73);
      chk("b_err_sat", 64'(b_err_cnt), 64'd15);
      chk("b_sat_err", 64'(b_cnt_sat), 64'd1);

      send(1'b0);
      chk("gap_bits_a", 64'(a_bit_cnt), 64'd74);
      idle();
      chk("gap_pulse", 64'(a_bit_err), 64'd0);
      chk("gap_bits", 64'(a_bit_cnt), 64'd74);
      chk("gap_locked", 64'(a_locked), 64'd1);
      send(1'b0);
      chk("gap_bits_c", 64'(a_bit_cnt), 64'd75);
      chk("gap_err", 64'(a_err_cnt), 64'd16);
      chk("gap_locked_c", 64'(a_locked), 64'd1);

      reset = 1'b1;
      clear = 1'b1;
      send(1'b1);
      reset = 1'b0;
      clear = 1'b0;
      chk("mrst_locked", 64'(a_locked), 64'd0);
      chk("mrst_err", 64'(a_err_cnt), 64'd0);
      chk("mrst_bits", 64'(a_bit_cnt), 64'd0);
      chk("mrst_pulse", 64'(a_bit_err), 64'd0);
      chk("mrst_b_sat", 64'(b_cnt_sat), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
